// File: rtl/uart_rx_core_pkg.sv
// Shared constants, LCR bit positions, FIFO entry layout and receiver FSM
// states for the UART receive path.
package uart_rx_core_pkg;

   localparam int FIFO_DEPTH = 16;
   localparam int FIFO_AW    = 4;
   localparam int COUNTER_W  = FIFO_AW + 1;
   localparam int REC_W      = 11;

   localparam int LCR_WLS_LO = 0;
   localparam int LCR_WLS_HI = 1;
   localparam int LCR_STB    = 2;
   localparam int LCR_PEN    = 3;
   localparam int LCR_EPS    = 4;
   localparam int LCR_SP     = 5;
   localparam int LCR_DLAB   = 7;

   localparam int REC_DATA_LO = 3;
   localparam int REC_DATA_HI = 10;
   localparam int REC_BRK     = 2;
   localparam int REC_PE      = 1;
   localparam int REC_FE      = 0;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_PUSH,
      S_WAIT_IDLE
   } rx_state_t;

   // Index of the final data bit for a word-length code (5..8 bits).
   function automatic logic [2:0] last_bit_idx(input logic [1:0] wls);
      return 3'd4 + {1'b0, wls};
   endfunction

endpackage

// File: rtl/uart_rx_core_if.sv
// Line-control, serial input and receive-FIFO read side of the UART receiver.
interface uart_rx_core_if;
   import uart_rx_core_pkg::*;

   logic [7:0]           lcr;
   logic                 enable;
   logic                 srx_pad_i;
   logic                 rf_pop;
   logic [REC_W-1:0]     rf_data_out;
   logic [COUNTER_W-1:0] rf_count;
   logic                 rf_error_bit;
   logic                 rf_overrun;
   logic                 rf_push_pulse;

   modport master (
      output lcr, enable, srx_pad_i, rf_pop,
      input  rf_data_out, rf_count, rf_error_bit, rf_overrun, rf_push_pulse
   );

   modport slave (
      input  lcr, enable, srx_pad_i, rf_pop,
      output rf_data_out, rf_count, rf_error_bit, rf_overrun, rf_push_pulse
   );

endinterface

// File: rtl/uart_rx_core_fifo.sv
// Receive FIFO: storage, wrapping pointers, sticky overrun flag and a count of
// held entries that carry an error status.
module uart_rx_core_fifo
   import uart_rx_core_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_push,
   input  logic [REC_W-1:0]     i_rec,
   input  logic                 i_pop,
   output logic [REC_W-1:0]     o_data,
   output logic [COUNTER_W-1:0] o_count,
   output logic                 o_error_bit,
   output logic                 o_overrun
);

   localparam logic [COUNTER_W-1:0] PTR_ONE = COUNTER_W'(1);
   localparam logic [COUNTER_W-1:0] FULL_CNT = COUNTER_W'(FIFO_DEPTH);

   logic [REC_W-1:0]     r_mem [FIFO_DEPTH];
   logic [COUNTER_W-1:0] r_wptr;
   logic [COUNTER_W-1:0] r_rptr;
   logic [COUNTER_W-1:0] r_err_cnt;
   logic                 r_overrun;

   logic [COUNTER_W-1:0] w_count;
   logic                 w_empty;
   logic                 w_full;
   logic                 w_pop_ok;
   logic                 w_push_ok;
   logic [REC_W-1:0]     w_head;
   logic                 w_err_inc;
   logic                 w_err_dec;

   assign w_count   = r_wptr - r_rptr;
   assign w_empty   = (w_count == '0);
   assign w_full    = (w_count == FULL_CNT);
   assign w_pop_ok  = i_pop && !w_empty;
   // A pop in the same cycle frees the slot the push needs.
   assign w_push_ok = i_push && (!w_full || w_pop_ok);
   assign w_head    = r_mem[r_rptr[FIFO_AW-1:0]];
   assign w_err_inc = w_push_ok && (|i_rec[REC_BRK:REC_FE]);
   assign w_err_dec = w_pop_ok && (|w_head[REC_BRK:REC_FE]);

   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         r_mem[r_wptr[FIFO_AW-1:0]] <= i_rec;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr    <= '0;
         r_rptr    <= '0;
         r_err_cnt <= '0;
         r_overrun <= 1'b0;
      end else begin
         if (w_push_ok) begin
            r_wptr <= r_wptr + PTR_ONE;
         end
         if (w_pop_ok) begin
            r_rptr <= r_rptr + PTR_ONE;
         end
         case ({w_err_inc, w_err_dec})
            2'b10:   r_err_cnt <= r_err_cnt + PTR_ONE;
            2'b01:   r_err_cnt <= r_err_cnt - PTR_ONE;
            default: r_err_cnt <= r_err_cnt;
         endcase
         if (i_push && !w_push_ok) begin
            r_overrun <= 1'b1;
         end else if (w_pop_ok) begin
            r_overrun <= 1'b0;
         end
      end
   end

   assign o_data      = w_empty ? '0 : w_head;
   assign o_count     = w_count;
   assign o_error_bit = (r_err_cnt != '0);
   assign o_overrun   = r_overrun;

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: 16x oversampled deserialiser with parity, framing and break
// detection feeding the receive FIFO.
module uart_rx_core
   import uart_rx_core_pkg::*;
(
   input  logic           clk,
   input  logic           rst_n,
   uart_rx_core_if.slave  bus
);

   rx_state_t  r_state;
   logic [1:0] r_cfg_wls;
   logic       r_cfg_pen;
   logic       r_cfg_eps;
   logic       r_cfg_sp;
   logic [3:0] r_tick;
   logic [2:0] r_bit;
   logic [7:0] r_data;
   logic       r_par_bit;
   logic       r_pe;
   logic       r_fe;
   logic       r_brk;
   logic       r_push;

   logic             w_par_expected;
   logic [REC_W-1:0] w_rec;
   logic             w_unused_lcr;

   // Unused data bits are zero, so the full-byte XOR is the word parity.
   assign w_par_expected = r_cfg_sp  ? ~r_cfg_eps :
                           r_cfg_eps ? (^r_data)  : ~(^r_data);
   assign w_rec          = {r_data, r_brk, r_pe, r_fe};
   assign w_unused_lcr   = &{bus.lcr[LCR_DLAB:6], bus.lcr[LCR_STB]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_cfg_wls <= 2'b00;
         r_cfg_pen <= 1'b0;
         r_cfg_eps <= 1'b0;
         r_cfg_sp  <= 1'b0;
         r_tick    <= 4'd0;
         r_bit     <= 3'd0;
         r_data    <= 8'd0;
         r_par_bit <= 1'b0;
         r_pe      <= 1'b0;
         r_fe      <= 1'b0;
         r_brk     <= 1'b0;
         r_push    <= 1'b0;
      end else begin
         r_push <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.enable && !bus.srx_pad_i) begin
                  r_cfg_wls <= bus.lcr[LCR_WLS_HI:LCR_WLS_LO];
                  r_cfg_pen <= bus.lcr[LCR_PEN];
                  r_cfg_eps <= bus.lcr[LCR_EPS];
                  r_cfg_sp  <= bus.lcr[LCR_SP];
                  r_tick    <= 4'd0;
                  r_state   <= S_START;
               end
            end
            S_START: begin
               if (bus.enable) begin
                  // Seventh tick after detection lands mid start bit.
                  if (r_tick == 4'd6) begin
                     r_tick <= 4'd0;
                     if (bus.srx_pad_i) begin
                        r_state <= S_IDLE;
                     end else begin
                        r_bit     <= 3'd0;
                        r_data    <= 8'd0;
                        r_par_bit <= 1'b0;
                        r_pe      <= 1'b0;
                        r_fe      <= 1'b0;
                        r_brk     <= 1'b0;
                        r_state   <= S_DATA;
                     end
                  end else begin
                     r_tick <= r_tick + 4'd1;
                  end
               end
            end
            S_DATA: begin
               if (bus.enable) begin
                  if (r_tick == 4'd15) begin
                     r_tick        <= 4'd0;
                     r_data[r_bit] <= bus.srx_pad_i;
                     r_bit         <= r_bit + 3'd1;
                     if (r_bit == last_bit_idx(r_cfg_wls)) begin
                        r_state <= r_cfg_pen ? S_PARITY : S_STOP;
                     end
                  end else begin
                     r_tick <= r_tick + 4'd1;
                  end
               end
            end
            S_PARITY: begin
               if (bus.enable) begin
                  if (r_tick == 4'd15) begin
                     r_tick    <= 4'd0;
                     r_par_bit <= bus.srx_pad_i;
                     r_pe      <= (bus.srx_pad_i != w_par_expected);
                     r_state   <= S_STOP;
                  end else begin
                     r_tick <= r_tick + 4'd1;
                  end
               end
            end
            S_STOP: begin
               if (bus.enable) begin
                  if (r_tick == 4'd15) begin
                     r_tick  <= 4'd0;
                     r_fe    <= ~bus.srx_pad_i;
                     r_brk   <= (r_data == 8'd0) && !r_par_bit && !bus.srx_pad_i;
                     r_state <= S_PUSH;
                  end else begin
                     r_tick <= r_tick + 4'd1;
                  end
               end
            end
            S_PUSH: begin
               r_push  <= 1'b1;
               r_state <= r_fe ? S_WAIT_IDLE : S_IDLE;
            end
            S_WAIT_IDLE: begin
               if (bus.enable && bus.srx_pad_i) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   uart_rx_core_fifo u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_push      (r_push),
      .i_rec       (w_rec),
      .i_pop       (bus.rf_pop),
      .o_data      (bus.rf_data_out),
      .o_count     (bus.rf_count),
      .o_error_bit (bus.rf_error_bit),
      .o_overrun   (bus.rf_overrun)
   );

   assign bus.rf_push_pulse = r_push;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: framing, parity, break, glitch rejection,
// FIFO full/overrun behaviour and asynchronous reset mid-frame.
module tb_uart_rx_core;
   import uart_rx_core_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   errors   = 0;
   int   checks   = 0;
   int   push_cnt = 0;
   int   p0;

   uart_rx_core_if bus ();

   uart_rx_core dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus.rf_push_pulse === 1'b1) push_cnt <= push_cnt + 1;
   end

   // Baud tick: one clk high every four clks, changed on the falling edge.
   initial begin : en_gen
      bus.enable = 1'b0;
      forever begin
         repeat (3) @(negedge clk);
         bus.enable = 1'b1;
         @(negedge clk);
         bus.enable = 1'b0;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_ticks(input int n);
      repeat (n) begin
         @(posedge clk);
         while (bus.enable !== 1'b1) @(posedge clk);
      end
   endtask

   task automatic drive_bit(input logic v);
      @(negedge clk);
      bus.srx_pad_i = v;
      wait_ticks(16);
   endtask

   task automatic send_char(input logic [7:0] d, input int nbits, input bit par_en, input logic par_bit);
      $display("tx char=%02h bits=%0d par_en=%0d par_bit=%0d", d, nbits, par_en, par_bit);
      drive_bit(1'b0);
      for (int i = 0; i < nbits; i++) drive_bit(d[i]);
      if (par_en) drive_bit(par_bit);
      drive_bit(1'b1);
      @(negedge clk);
   endtask

   task automatic pop_one();
      @(negedge clk);
      bus.rf_pop = 1'b1;
      @(negedge clk);
      bus.rf_pop = 1'b0;
   endtask

   // 8N1 character whose FIFO write is met by a pop in the same clk.
   task automatic send_char_pop(input logic [7:0] d);
      bit found;
      found = 1'b0;
      $display("tx char=%02h with pop on push", d);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
      @(negedge clk);
      bus.srx_pad_i = 1'b1;
      for (int k = 0; k < 400 && !found; k++) begin
         if (bus.rf_push_pulse === 1'b1) begin
            bus.rf_pop = 1'b1;
            found = 1'b1;
         end
         @(negedge clk);
      end
      bus.rf_pop = 1'b0;
      check("push_seen_for_pop", {31'd0, found}, 32'd1);
      wait_ticks(16);
      @(negedge clk);
   endtask

   initial begin
      bus.lcr       = 8'h03;
      bus.srx_pad_i = 1'b1;
      bus.rf_pop    = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_count",   bus.rf_count,      0);
      check("rst_data",    bus.rf_data_out,   0);
      check("rst_err",     bus.rf_error_bit,  0);
      check("rst_overrun", bus.rf_overrun,    0);
      check("rst_push",    bus.rf_push_pulse, 0);
      rst_n = 1'b1;
      wait_ticks(20);

      // 8N1 0xA5
      p0 = push_cnt;
      send_char(8'hA5, 8, 1'b0, 1'b0);
      check("a5_pushes", push_cnt - p0,   1);
      check("a5_data",   bus.rf_data_out, 11'h528);
      check("a5_count",  bus.rf_count,    1);
      check("a5_err",    bus.rf_error_bit, 0);
      pop_one();
      check("a5_pop_count", bus.rf_count,    0);
      check("a5_pop_data",  bus.rf_data_out, 0);

      // 7E1 0x35 with wrong parity bit
      bus.lcr = 8'h1A;
      send_char(8'h35, 7, 1'b1, 1'b1);
      check("pe_data",  bus.rf_data_out,  11'h1AA);
      check("pe_err",   bus.rf_error_bit, 1);
      pop_one();
      check("pe_pop_err",   bus.rf_error_bit, 0);
      check("pe_pop_count", bus.rf_count,     0);
      bus.lcr = 8'h03;

      // Break: line low for 40 bit times
      p0 = push_cnt;
      @(negedge clk);
      bus.srx_pad_i = 1'b0;
      $display("tx break 40 bit times");
      wait_ticks(40 * 16);
      @(negedge clk);
      check("brk_pushes", push_cnt - p0,    1);
      check("brk_data",   bus.rf_data_out,  11'h005);
      check("brk_count",  bus.rf_count,     1);
      check("brk_err",    bus.rf_error_bit, 1);
      bus.srx_pad_i = 1'b1;
      wait_ticks(48);
      @(negedge clk);
      check("brk_idle_pushes", push_cnt - p0, 1);
      send_char(8'h3C, 8, 1'b0, 1'b0);
      check("brk_next_pushes", push_cnt - p0, 2);
      check("brk_next_count",  bus.rf_count,  2);
      pop_one();
      check("brk_pop_err",  bus.rf_error_bit, 0);
      check("brk_pop_head", bus.rf_data_out,  11'h1E0);
      pop_one();
      check("brk_pop_count", bus.rf_count, 0);

      // Short low glitch while idle
      p0 = push_cnt;
      @(negedge clk);
      bus.srx_pad_i = 1'b0;
      $display("tx glitch 4 ticks");
      wait_ticks(4);
      @(negedge clk);
      bus.srx_pad_i = 1'b1;
      wait_ticks(32);
      @(negedge clk);
      check("glitch_pushes", push_cnt - p0, 0);
      check("glitch_count",  bus.rf_count,  0);
      pop_one();
      check("empty_pop_count", bus.rf_count, 0);

      // 17 characters, no pops
      p0 = push_cnt;
      for (int i = 0; i < 17; i++) send_char(8'h10 + 8'(i), 8, 1'b0, 1'b0);
      check("full_pushes",  push_cnt - p0,   17);
      check("full_count",   bus.rf_count,    16);
      check("full_overrun", bus.rf_overrun,  1);
      check("full_head",    bus.rf_data_out, 11'h080);
      pop_one();
      check("ovr_pop_overrun", bus.rf_overrun,  0);
      check("ovr_pop_count",   bus.rf_count,    15);
      check("ovr_pop_head",    bus.rf_data_out, 11'h088);

      // Refill, then push coinciding with pop while full
      send_char(8'h40, 8, 1'b0, 1'b0);
      check("refill_count",   bus.rf_count,   16);
      check("refill_overrun", bus.rf_overrun, 0);
      send_char_pop(8'h41);
      check("pp_count",   bus.rf_count,    16);
      check("pp_overrun", bus.rf_overrun,  0);
      check("pp_head",    bus.rf_data_out, 11'h090);

      // Asynchronous reset mid-frame
      $display("tx partial frame then reset");
      drive_bit(1'b0);
      drive_bit(1'b1);
      drive_bit(1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      bus.srx_pad_i = 1'b1;
      #1;
      check("mrst_count",   bus.rf_count,      0);
      check("mrst_data",    bus.rf_data_out,   0);
      check("mrst_err",     bus.rf_error_bit,  0);
      check("mrst_overrun", bus.rf_overrun,    0);
      check("mrst_push",    bus.rf_push_pulse, 0);
      @(negedge clk);
      rst_n = 1'b1;
      wait_ticks(32);
      send_char(8'h5A, 8, 1'b0, 1'b0);
      check("post_rst_count", bus.rf_count,     1);
      check("post_rst_data",  bus.rf_data_out,  11'h2D0);
      check("post_rst_err",   bus.rf_error_bit, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
